// File: rtl/unidade_controle_rodadas.sv
// unidade_controle_rodadas
// Round-based control unit for the sequence-memory game. Round r asks for
// r+1 correct plays; the block owns the play-address and round counters,
// enforces an optional per-play inactivity timeout and holds the final
// result (win / error / timeout) until the next start request.
//
// Ports
//   i_clock         system clock, all state on rising edge
//   i_reset         asynchronous active-low reset
//   i_iniciar       start request (level, sampled in inicial/terminal states)
//   i_jogada        one-cycle pulse: a play has been made
//   i_igual         comparator result, valid in comparacao
//   i_modo_timeout  1 = inactivity timeout enabled
//   o_zeraR         clear play register (one cycle per start)
//   o_registraR     load play register (one cycle per accepted play)
//   o_endereco      sequence-memory address of the expected play
//   o_rodada        current round (0-based)
//   o_acertou/o_errou/o_timeout  result flags, held in terminal states
//   o_pronto        OR of the result flags
//   o_db_estado     state code (F for any illegal code)
//   o_db_rodada     copy of o_rodada
//
// state          | code | meaning
// inicial        | 0    | idle, waiting for iniciar
// preparacao     | 1    | clear counters and play register
// inicia_rodada  | 2    | restart address/timer for a new round
// espera         | 3    | waiting for a play, timer running
// registra       | 4    | latch the play
// comparacao     | 5    | check play against memory
// proximo        | 6    | advance address inside the round
// proxima_rodada | 7    | advance round
// fim_acerto     | C    | game won, result held
// fim_erro       | D    | wrong play, result held
// fim_timeout    | E    | inactivity timeout, result held

module unidade_controle_rodadas #(
    parameter int N_ROUNDS       = 16,
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_iniciar,
    input  logic              i_jogada,
    input  logic              i_igual,
    input  logic              i_modo_timeout,
    output logic              o_zeraR,
    output logic              o_registraR,
    output logic [ADDR_W-1:0] o_endereco,
    output logic [ADDR_W-1:0] o_rodada,
    output logic              o_acertou,
    output logic              o_errou,
    output logic              o_timeout,
    output logic              o_pronto,
    output logic [3:0]        o_db_estado,
    output logic [ADDR_W-1:0] o_db_rodada
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0]  TMR_ULTIMO  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] RODADA_FIM  = ADDR_W'(N_ROUNDS - 1);

    typedef enum logic [3:0] {
        S_INICIAL        = 4'h0,
        S_PREPARACAO     = 4'h1,
        S_INICIA_RODADA  = 4'h2,
        S_ESPERA         = 4'h3,
        S_REGISTRA       = 4'h4,
        S_COMPARACAO     = 4'h5,
        S_PROXIMO        = 4'h6,
        S_PROXIMA_RODADA = 4'h7,
        S_FIM_ACERTO     = 4'hC,
        S_FIM_ERRO       = 4'hD,
        S_FIM_TIMEOUT    = 4'hE
    } estado_t;

    estado_t           r_estado;
    logic [ADDR_W-1:0] r_endereco;
    logic [ADDR_W-1:0] r_rodada;
    logic [TMR_W-1:0]  r_timer;
    logic              r_zera;
    logic              r_registra;
    logic              r_acertou;
    logic              r_errou;
    logic              r_timeout;
    logic              r_pronto;

    estado_t           w_prox;
    logic [ADDR_W-1:0] w_endereco;
    logic [ADDR_W-1:0] w_rodada;
    logic [TMR_W-1:0]  w_timer;
    logic [3:0]        w_db_estado;

    always_comb begin
        w_prox     = r_estado;
        w_endereco = r_endereco;
        w_rodada   = r_rodada;
        w_timer    = r_timer;
        case (r_estado)
            S_INICIAL: begin
                if (i_iniciar) begin
                    w_prox     = S_PREPARACAO;
                    w_rodada   = '0;
                    w_endereco = '0;
                    w_timer    = '0;
                end
            end
            S_PREPARACAO: begin
                w_prox     = S_INICIA_RODADA;
                w_rodada   = '0;
                w_endereco = '0;
                w_timer    = '0;
            end
            S_INICIA_RODADA: begin
                w_prox     = S_ESPERA;
                w_endereco = '0;
                w_timer    = '0;
            end
            S_ESPERA: begin
                // a play on the last timer cycle still counts
                if (i_jogada)
                    w_prox = S_REGISTRA;
                else if (i_modo_timeout && (r_timer == TMR_ULTIMO))
                    w_prox = S_FIM_TIMEOUT;
                else if (i_modo_timeout)
                    w_timer = r_timer + TMR_W'(1);
            end
            S_REGISTRA:   w_prox = S_COMPARACAO;
            S_COMPARACAO: begin
                if (!i_igual)
                    w_prox = S_FIM_ERRO;
                else if ((r_endereco == r_rodada) && (r_rodada == RODADA_FIM))
                    w_prox = S_FIM_ACERTO;
                else if (r_endereco == r_rodada)
                    w_prox = S_PROXIMA_RODADA;
                else
                    w_prox = S_PROXIMO;
            end
            S_PROXIMO: begin
                w_prox     = S_ESPERA;
                w_endereco = r_endereco + ADDR_W'(1);
                w_timer    = '0;
            end
            S_PROXIMA_RODADA: begin
                w_prox   = S_INICIA_RODADA;
                w_rodada = r_rodada + ADDR_W'(1);
            end
            S_FIM_ACERTO, S_FIM_ERRO, S_FIM_TIMEOUT: begin
                // counters are cleared on the way out so preparacao already shows 0
                if (i_iniciar) begin
                    w_prox     = S_PREPARACAO;
                    w_rodada   = '0;
                    w_endereco = '0;
                    w_timer    = '0;
                end
            end
            default: w_prox = S_INICIAL;
        endcase
    end

    always_comb begin
        w_db_estado = 4'hF;
        case (r_estado)
            S_INICIAL, S_PREPARACAO, S_INICIA_RODADA, S_ESPERA, S_REGISTRA,
            S_COMPARACAO, S_PROXIMO, S_PROXIMA_RODADA, S_FIM_ACERTO,
            S_FIM_ERRO, S_FIM_TIMEOUT: w_db_estado = r_estado;
            default: w_db_estado = 4'hF;
        endcase
    end

    // outputs are decoded from the next state so they line up with r_estado
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_estado   <= S_INICIAL;
            r_endereco <= '0;
            r_rodada   <= '0;
            r_timer    <= '0;
            r_zera     <= 1'b0;
            r_registra <= 1'b0;
            r_acertou  <= 1'b0;
            r_errou    <= 1'b0;
            r_timeout  <= 1'b0;
            r_pronto   <= 1'b0;
        end else begin
            r_estado   <= w_prox;
            r_endereco <= w_endereco;
            r_rodada   <= w_rodada;
            r_timer    <= w_timer;
            r_zera     <= (w_prox == S_PREPARACAO);
            r_registra <= (w_prox == S_REGISTRA);
            r_acertou  <= (w_prox == S_FIM_ACERTO);
            r_errou    <= (w_prox == S_FIM_ERRO);
            r_timeout  <= (w_prox == S_FIM_TIMEOUT);
            r_pronto   <= (w_prox == S_FIM_ACERTO) || (w_prox == S_FIM_ERRO) ||
                          (w_prox == S_FIM_TIMEOUT);
        end
    end

    assign o_zeraR     = r_zera;
    assign o_registraR = r_registra;
    assign o_endereco  = r_endereco;
    assign o_rodada    = r_rodada;
    assign o_db_rodada = r_rodada;
    assign o_acertou   = r_acertou;
    assign o_errou     = r_errou;
    assign o_timeout   = r_timeout;
    assign o_pronto    = r_pronto;
    assign o_db_estado = w_db_estado;

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Testbench for unidade_controle_rodadas: directed games from the test plan
// plus randomized games, all predicted by a play-level game model.
module tb_unidade_controle_rodadas;

    localparam int NR  = 4;
    localparam int AW  = 4;
    localparam int TMO = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          iniciar, jogada, igual, modo;
    logic          zera, registra, acertou, errou, tmo_flag, pronto;
    logic [AW-1:0] endereco, rodada, db_rodada;
    logic [3:0]    estado;

    int n_chk  = 0;
    int n_pass = 0;
    int n_reg  = 0;
    int n_zera = 0;

    unidade_controle_rodadas #(
        .N_ROUNDS(NR), .ADDR_W(AW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clock(clk), .i_reset(rst_n), .i_iniciar(iniciar), .i_jogada(jogada),
        .i_igual(igual), .i_modo_timeout(modo),
        .o_zeraR(zera), .o_registraR(registra), .o_endereco(endereco),
        .o_rodada(rodada), .o_acertou(acertou), .o_errou(errou),
        .o_timeout(tmo_flag), .o_pronto(pronto), .o_db_estado(estado),
        .o_db_rodada(db_rodada)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (registra) n_reg  <= n_reg + 1;
        if (zera)     n_zera <= n_zera + 1;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, got hang, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic pick_modo(input int sel);
        if (sel == 2) return logic'($urandom_range(0, 1));
        return logic'(sel == 1);
    endfunction

    task automatic chk_idle_zero(input string tag);
        chk({tag, " estado"}, estado, 0);
        chk({tag, " endereco"}, endereco, 0);
        chk({tag, " rodada"}, rodada, 0);
        chk({tag, " flags"}, {zera, registra, acertou, errou, tmo_flag, pronto}, 0);
    endtask

    task automatic iniciar_partida();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        chk("start estado", estado, 1);
        chk("start zeraR", zera, 1);
        chk("start flags", {acertou, errou, tmo_flag, pronto}, 0);
        chk("start rodada", rodada, 0);
        chk("start endereco", endereco, 0);
        tick();
        chk("inicia_rodada estado", estado, 2);
        chk("inicia zeraR", zera, 0);
        tick();
        chk("espera estado", estado, 3);
    endtask

    // modo_sel: 0 off, 1 on, 2 random per cycle
    // erro_idx: play index answered wrong (-1 none, -2 random)
    // atraso: idle cycles before each play (-1 random)
    // parar_em: play index before which reset is pulsed (-1 never)
    task automatic jogar(input int modo_sel, input int erro_idx, input int atraso,
                         input int parar_em, input int hold);
        int r, a, cnt, n_play, d, reg0, zer0, fim_cod;
        bit fim, ok;
        reg0 = n_reg;
        zer0 = n_zera;
        iniciar_partida();
        r = 0; a = 0; n_play = 0; fim = 0; fim_cod = 0;
        while (!fim) begin
            cnt = 0;
            if (atraso >= 0) d = atraso;
            else if ($urandom_range(0, 3) == 0) d = $urandom_range(0, TMO + 3);
            else d = $urandom_range(0, 5);
            if (n_play == parar_em) begin
                tick(); tick();
                #2 rst_n = 1'b0;
                #1 chk_idle_zero("async reset");
                #3 rst_n = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    jogada = logic'(i == 2);
                    tick();
                end
                jogada = 1'b0;
                chk_idle_zero("after reset");
                return;
            end
            for (int i = 0; i < d && !fim; i++) begin
                modo = pick_modo(modo_sel);
                jogada = 1'b0;
                tick();
                if (modo && cnt == TMO - 1) begin
                    fim = 1; fim_cod = 14;
                end else begin
                    if (modo) cnt++;
                    chk("espera hold", estado, 3);
                end
            end
            if (fim) break;
            modo = pick_modo(modo_sel);
            if (erro_idx == -2) ok = ($urandom_range(0, 14) != 0);
            else ok = (n_play != erro_idx);
            jogada = 1'b1;
            tick();
            jogada = logic'($urandom_range(0, 1));
            igual = ok;
            chk("registra estado", estado, 4);
            chk("registraR", registra, 1);
            tick();
            jogada = logic'($urandom_range(0, 1));
            chk("comparacao estado", estado, 5);
            chk("registraR low", registra, 0);
            tick();
            jogada = 1'b0;
            n_play++;
            if (!ok) begin
                fim = 1; fim_cod = 13;
            end else if (a == r && r == NR - 1) begin
                fim = 1; fim_cod = 12;
            end else if (a == r) begin
                chk("proxima_rodada", estado, 7);
                tick();
                chk("inicia_rodada", estado, 2);
                tick();
                r++; a = 0;
                chk("round espera", estado, 3);
                chk("round rodada", rodada, r);
                chk("round endereco", endereco, 0);
            end else begin
                chk("proximo", estado, 6);
                tick();
                a++;
                chk("next espera", estado, 3);
                chk("next endereco", endereco, a);
            end
        end
        chk("end estado", estado, fim_cod);
        chk("end flags", {acertou, errou, tmo_flag},
            {fim_cod == 12, fim_cod == 13, fim_cod == 14});
        chk("end pronto", pronto, 1);
        chk("end rodada", rodada, r);
        chk("end db_rodada", db_rodada, r);
        chk("end endereco", endereco, a);
        chk("registraR count", n_reg - reg0, n_play);
        chk("zeraR count", n_zera - zer0, 1);
        for (int i = 0; i < hold; i++) begin
            jogada = logic'($urandom_range(0, 1));
            modo = logic'($urandom_range(0, 1));
            tick();
        end
        jogada = 1'b0;
        chk("held estado", estado, fim_cod);
        chk("held pronto", pronto, 1);
        chk("held rodada", rodada, r);
        chk("held endereco", endereco, a);
        chk("held registraR count", n_reg - reg0, n_play);
    endtask

    initial begin
        rst_n = 1'b0; iniciar = 1'b0; jogada = 1'b0; igual = 1'b0; modo = 1'b0;
        repeat (3) tick();
        chk_idle_zero("reset");
        chk("reset db_estado", estado, 0);
        rst_n = 1'b1;
        tick();
        jogada = 1'b1;
        tick();
        jogada = 1'b0;
        tick();
        chk_idle_zero("jogada in inicial");

        jogar(0, -1, 2, -1, 100);      // full win, flags held
        jogar(0, 4, 1, -1, 5);         // wrong on 2nd play of round 2
        jogar(1, -1, 30, -1, 5);       // timeout exactly TMO edges into espera
        jogar(0, -1, 1000, -1, 5);     // timeout disabled: long waits, then win
        jogar(1, -1, TMO - 1, -1, 5);  // play on the last timer cycle every time
        jogar(0, -1, 1, 3, 0);         // reset during espera of round 2
        for (int g = 0; g < 12; g++)
            jogar($urandom_range(0, 2), -2, -1, -1, $urandom_range(1, 8));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/unidade_controle_rodadas.md
# unidade_controle_rodadas

Parametrised control unit for the sequence-memory game. It extends the single-pass compare controller with progressive rounds: round r requires r+1 correct plays. It adds a per-play inactivity timeout and terminal states that hold their result until the next start. The block sits between the button edge detector / data comparator and the sequence memory, and it owns the play-address and round counters itself.

## Interface
- N_ROUNDS, 16: maximum sequence length; game is won after round N_ROUNDS-1 completes (legal 2..2**ADDR_W)
- ADDR_W, 4: width of address and round counters
- TIMEOUT_CYCLES, 5000: clock cycles allowed in espera before timeout (≥2)
- clock  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- iniciar  input  1  start request, level-sampled in inicial and terminal states
- jogada  input  1  one-cycle pulse, a play has been made (from edge detector)
- igual  input  1  comparator result, valid in comparacao
- modo_timeout  input  1  1 = timeout enabled, 0 = wait forever
- zeraR  output  1  clear play register
- registraR  output  1  load play register
- endereco  output  ADDR_W  sequence-memory address of expected play
- rodada  output  ADDR_W  current round index (0-based)
- acertou / errou / timeout  output  1  result flags, held in terminal states
- pronto  output  1  OR of the three result flags
- db_estado  output  4  state code
- db_rodada  output  ADDR_W  copy of rodada

## Operation
- States (db_estado): inicial 0, preparacao 1, inicia_rodada 2, espera 3, registra 4, comparacao 5, proximo 6, proxima_rodada 7, fim_acerto C, fim_erro D, fim_timeout E. Any unused code reads F and returns to inicial.
- inicial: iniciar=1 → preparacao.
- preparacao: rodada←0, endereco←0, timer←0, zeraR=1 → inicia_rodada.
- inicia_rodada: endereco←0, timer←0 → espera.
- espera: if jogada → registra. Else if modo_timeout and timer==TIMEOUT_CYCLES-1 → fim_timeout. Else timer+1 (when modo_timeout=1) and stay. jogada wins over timeout in the same cycle.
- registra: registraR=1 → comparacao.
- comparacao: If igual=0 → fim_erro. Else if endereco==rodada and rodada==N_ROUNDS-1 → fim_acerto. Else if endereco==rodada → proxima_rodada. Else → proximo.
- proximo: endereco+1, timer←0 → espera.
- proxima_rodada: rodada+1 → inicia_rodada.
- Terminal states: the flag is held (acertou/errou/timeout, plus pronto). endereco and rodada are frozen. iniciar=1 → preparacao; otherwise stay.
- Counters never wrap in legal operation; rodada ≤ N_ROUNDS-1, endereco ≤ rodada.
- jogada pulses outside espera are ignored.

## Timing
- Reset (reset=0, asynchronous): state inicial, endereco=0, rodada=0, timer=0. All outputs are 0 except db_estado=0. Asserting reset mid-game aborts immediately, with no terminal flag.
- Moore outputs, registered state: zeraR is high exactly 1 cycle per start. registraR is high exactly 1 cycle per accepted play.
- jogada sampled high in espera at edge k: registra during k..k+1, comparacao during k+1..k+2, next state entered at edge k+2.
- Non-final correct play: back in espera 3 cycles after the jogada edge, with endereco incremented.
- Round advance: proxima_rodada → inicia_rodada → espera, 4 cycles after the jogada edge.
- Timeout: with modo_timeout=1 and no jogada, fim_timeout is entered TIMEOUT_CYCLES edges after entering espera. Timer restarts on every entry to espera.
- Changing modo_timeout mid-espera freezes/resumes the timer without clearing it.
- Terminal → preparacao takes 1 cycle after iniciar is sampled. The flags drop on that same edge.

## Test plan
- Reset mid-game: N_ROUNDS=4. Pulse reset low during espera of round 2 → state 0, endereco=0, rodada=0, no flag. After release, idle until iniciar.
- Full win: N_ROUNDS=4, modo_timeout=0, igual=1 on every play. Plays total 1+2+3+4=10, registraR pulses=10 → fim_acerto (C), acertou=pronto=1 held ≥100 cycles, rodada=3.
- Error in round 2: igual=0 on the 2nd play of rodada=2 → fim_erro (D), errou=1, endereco=1, rodada=2. iniciar → preparacao, flags cleared, rodada=0.
- Timeout: TIMEOUT_CYCLES=20, modo_timeout=1, no plays after start. fim_timeout (E) is entered exactly 20 edges after entering espera, timeout=1. Same stimulus with modo_timeout=0 stays in espera for 1000 cycles.
- Timer boundary: jogada arrives on the cycle timer==19 → registra, not timeout. Timer reloads to 0 on the return to espera.
- Ignored input: jogada pulses during registra/comparacao/inicial → no extra registraR and no state change.
